// File: rtl/shift_rows_pipe.sv
// AES ShiftRows / InvShiftRows over an NB-column state, selectable per block.
// Latency: 1 cycle from the acceptance edge to out_valid (output register empty or draining).
// Backpressure: output register plus one skid register; in_ready is registered and
// drops only once the skid register holds a block.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     input handshake; in_inv selects inverse mode for that block
//   in_data [32*NB]       input state, byte (r,c) at bits [8*(4c+r) +: 8]
//   out_valid/out_ready   output handshake; out_data is zero while out_valid=0
//   blk_cnt [32]          saturating accepted-block count (only with SHIFTROWS_CNT_EN)
//
// Build option: define SHIFTROWS_CNT_EN to add the blk_cnt port and counter.
module shift_rows_pipe #(
    parameter int NB = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
    input  logic [32*NB-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_data
`ifdef SHIFTROWS_CNT_EN
    ,
    output logic [31:0]      blk_cnt
`endif
);

    localparam int W = 32 * NB;

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    // Row r of the state is rotated left by s(r) columns (forward) or right
    // by s(r) (inverse). Only the 8-column state uses offsets 0,1,3,4.
    function automatic logic [W-1:0] shift_rows(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] res;
        int           s;
        int           src;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            s = (NB == 8 && r >= 2) ? r + 1 : r;
            for (int c = 0; c < NB; c++) begin
                src = inv ? (c - s + NB) % NB : (c + s) % NB;
                res[8*(4*c+r) +: 8] = d[8*(4*src+r) +: 8];
            end
        end
        return res;
    endfunction

    logic         out_vld_q, out_vld_d;
    logic [W-1:0] out_dat_q, out_dat_d;
    logic         skid_vld_q, skid_vld_d;
    logic [W-1:0] skid_dat_q, skid_dat_d;
    logic         in_rdy_q, in_rdy_d;
    logic         accept;
    logic         consume;
    logic [W-1:0] xform;

    always_comb begin
        accept     = in_valid & in_rdy_q;
        consume    = out_vld_q & out_ready;
        xform      = shift_rows(in_data, in_inv);
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;

        if (skid_vld_q) begin
            // in_ready is low while the skid is full, so nothing is accepted here.
            if (consume) begin
                out_vld_d  = 1'b1;
                out_dat_d  = skid_dat_q;
                skid_vld_d = 1'b0;
                skid_dat_d = '0;
            end
        end else if (!out_vld_q || consume) begin
            // Output register free this edge: load directly, or go idle with zeroed data.
            out_vld_d = accept;
            out_dat_d = accept ? xform : '0;
        end else if (accept) begin
            // Output stalled: park the new block in the skid register.
            skid_vld_d = 1'b1;
            skid_dat_d = xform;
        end

        in_rdy_d = ~skid_vld_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            // Held low during reset so nothing can handshake; rises on the first
            // edge after release.
            in_rdy_q   <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            in_rdy_q   <= in_rdy_d;
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;

`ifdef SHIFTROWS_CNT_EN
    logic [31:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (accept && blk_cnt_q != 32'hFFFF_FFFF) begin
            blk_cnt_d = blk_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule
